l_shift_sat_12: RTL and testbench
=================================

L_SHIFT_SAT_12 -- requirements
Module: l_shift_sat_12

Interface
REQ-001 The module SHALL have parameter SAT_EN, default 1, meaning that 1 clamps results on overflow and 0 returns the wrapped result.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a shift; sampled only in IDLE.
REQ-005 The module SHALL have port Inpt, input, 12 bits: two's-complement operand; captured at the accepted start edge.
REQ-006 The module SHALL have port I, input, 4 bits: left-shift amount 0..15; captured together with Inpt.
REQ-007 The module SHALL have port Otps, output, 12 bits: registered two's-complement result; holds between operations.
REQ-008 The module SHALL have port ovf, output, 1 bit: registered overflow flag for the last completed operation.
REQ-009 The module SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 The module SHALL have port done, output, 1 bit: single-cycle pulse marking when Otps and ovf have been updated.

Function
REQ-011 The module SHALL implement three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE, start=1 at an edge SHALL load the working register with Inpt, the counter with I, clear internal overflow, and save the sign as Inpt[11].
REQ-013 At that start edge, the next state SHALL be DONE if I=0, else SHIFT.
REQ-014 In SHIFT, each edge SHALL shift the working register left by one with zero fill and decrement the counter.
REQ-015 At each SHIFT edge, internal overflow SHALL be set (sticky) if work[11] != work[10] before that shift.
REQ-016 SHIFT SHALL go to DONE on the edge where the counter goes from 1 to 0.
REQ-017 Latency: with start accepted at edge k, the state SHALL be DONE, with done=1, in the cycle after edge k+I (I=0 gives 1 cycle, I=15 gives 16 cycles).
REQ-018 At the edge entering DONE, Otps and ovf SHALL be written.
  - Otps = work when no overflow, or when SAT_EN=0.
  - Otps = 12'h7FF when overflow, SAT_EN=1 and sign=0.
  - Otps = 12'h800 when overflow, SAT_EN=1 and sign=1.
REQ-019 DONE SHALL last exactly one cycle (done=1, busy=1) and then return to IDLE unconditionally.
REQ-020 start SHALL be ignored in SHIFT and DONE; no queuing; Inpt and I changes while busy have no effect.
REQ-021 A start held high SHALL be re-accepted on the first IDLE edge after DONE, so back-to-back operations are spaced I+2 edges apart.
REQ-022 When no overflow occurs, arithmetic right shift of Otps by I SHALL return the captured Inpt exactly (inverse of the existing right-shift unit).
REQ-023 Otps and ovf SHALL change only at entry to DONE or on reset.
REQ-024 done SHALL never be high in two consecutive cycles.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, Otps=12'h000, ovf=0, done=0, busy=0, counter=0 and work=0.
REQ-026 Reset asserted during SHIFT or DONE SHALL abort the operation without producing a done pulse.
REQ-027 After reset release, the first start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-028 Inpt=12'h005, I=3 -> done in the cycle after edge k+3, Otps=12'h028, ovf=0, busy high for 4 cycles.
REQ-029 Inpt=12'hFFB, I=4 -> Otps=12'hFB0, ovf=0; right-shifting Otps by 4 gives 12'hFFB.
REQ-030 Inpt=12'h100, I=4, SAT_EN=1 -> ovf=1, Otps=12'h7FF; with SAT_EN=0 -> ovf=1, Otps=12'h000.
REQ-031 Inpt=12'h800, I=1, SAT_EN=1 -> ovf=1, Otps=12'h800; then Inpt=12'h123, I=0 -> done one cycle after start, Otps=12'h123, ovf=0.
REQ-032 start re-pulsed during SHIFT with different Inpt -> ignored, result matches the first operand; start held high -> second operation accepted on the edge after DONE.
REQ-033 rst_n driven low mid-SHIFT between clock edges -> busy=0, Otps=12'h000 immediately, no done pulse; next start completes normally.

Source files
------------

// File: rtl/l_shift_sat_12.sv
// l_shift_sat_12 -- sequential left shifter for 12-bit two's-complement
// operands, one bit per clock, with optional saturation on overflow.
//
// Parameters:
//   SAT_EN : 1 clamps overflowed results to 12'h7FF / 12'h800 by operand
//            sign; 0 returns the wrapped (plain shifted) value.
// Ports:
//   clk    : clock, rising-edge active
//   rst_n  : asynchronous active-low reset
//   start  : begin an operation; sampled only while idle
//   Inpt   : 12-bit signed operand, captured when start is accepted
//   I      : shift amount 0..15, captured together with Inpt
//   Otps   : registered result, held between operations
//   ovf    : registered overflow flag of the last completed operation
//   busy   : high while an operation is in progress (SHIFT or DONE)
//   done   : one-cycle pulse; Otps/ovf were updated at the edge entering it
module l_shift_sat_12 #(
    parameter int SAT_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] Inpt,
    input  logic [3:0]  I,
    output logic [11:0] Otps,
    output logic        ovf,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [11:0] work;
    logic [3:0]  cnt;
    logic        ovf_int;
    logic        sign;

    logic [11:0] shifted;
    logic        step_ovf;
    logic [11:0] res_work;
    logic        res_ovf;
    logic        res_sign;
    logic [11:0] res_out;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (I == 4'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 4'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // One shift step; overflow is detected before the shift, when the bit
    // about to become the sign differs from the current sign.
    always_comb begin
        shifted  = {work[10:0], 1'b0};
        step_ovf = work[11] ^ work[10];
    end

    // Value written to Otps/ovf at the edge entering DONE. From IDLE this is
    // the zero-shift case (operand passes straight through); from SHIFT it
    // includes the final step being taken on that same edge.
    always_comb begin
        if (state == IDLE) begin
            res_work = Inpt;
            res_ovf  = 1'b0;
            res_sign = Inpt[11];
        end else begin
            res_work = shifted;
            res_ovf  = ovf_int | step_ovf;
            res_sign = sign;
        end
        if (res_ovf && (SAT_EN != 0)) begin
            res_out = res_sign ? 12'h800 : 12'h7FF;
        end else begin
            res_out = res_work;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work    <= '0;
            cnt     <= '0;
            ovf_int <= 1'b0;
            sign    <= 1'b0;
            Otps    <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work    <= Inpt;
                        cnt     <= I;
                        ovf_int <= 1'b0;
                        sign    <= Inpt[11];
                    end
                end
                SHIFT: begin
                    work    <= shifted;
                    cnt     <= cnt - 4'd1;
                    ovf_int <= ovf_int | step_ovf;
                end
                default: ;
            endcase
            if (state_nxt == DONE) begin
                Otps <= res_out;
                ovf  <= res_ovf;
            end
        end
    end

endmodule

// File: tb/tb_l_shift_sat_12.sv
module tb_l_shift_sat_12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] inpt = 12'h000;
    logic [3:0]  sh = 4'd0;

    logic [11:0] otps1, otps0;
    logic        ovf1, ovf0, busy1, busy0, done1, done0;

    int total = 0;
    int bad = 0;

    l_shift_sat_12 #(.SAT_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Inpt(inpt), .I(sh),
        .Otps(otps1), .ovf(ovf1), .busy(busy1), .done(done1)
    );

    l_shift_sat_12 #(.SAT_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .Inpt(inpt), .I(sh),
        .Otps(otps0), .ovf(ovf0), .busy(busy0), .done(done0)
    );

    always #5 clk = ~clk;

    task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Bounded wait for done, counted in negedges from the current one.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done1 !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic launch(input logic [11:0] a, input logic [3:0] s);
        @(negedge clk);
        inpt  = a;
        sh    = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge following the accepting edge; ncyc is how many
    // more negedges until done is expected.
    task automatic finish_op(input string tag, input int ncyc,
                             input logic [11:0] e1, input logic v1,
                             input logic [11:0] e0, input logic v0);
        int cyc;
        chk1({tag, "_busy_start"}, busy1, 1'b1);
        wait_done(cyc);
        chki({tag, "_latency"}, cyc, ncyc);
        chk1({tag, "_done_sat0"}, done0, 1'b1);
        chk12({tag, "_otps"}, otps1, e1);
        chk1({tag, "_ovf"}, ovf1, v1);
        chk12({tag, "_otps_sat0"}, otps0, e0);
        chk1({tag, "_ovf_sat0"}, ovf0, v0);
        chk1({tag, "_busy_done"}, busy1, 1'b1);
        @(negedge clk);
        chk1({tag, "_done_1cyc"}, done1, 1'b0);
        chk1({tag, "_busy_end"}, busy1, 1'b0);
        chk12({tag, "_otps_hold"}, otps1, e1);
    endtask

    initial begin
        logic signed [11:0] tmp;

        // reset state
        repeat (2) @(negedge clk);
        chk12("rst_otps", otps1, 12'h000);
        chk1("rst_ovf", ovf1, 1'b0);
        chk1("rst_busy", busy1, 1'b0);
        chk1("rst_done", done1, 1'b0);

        // start accepted on first edge after release
        rst_n = 1'b1;
        inpt  = 12'h005;
        sh    = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_op("op005", 3, 12'h028, 1'b0, 12'h028, 1'b0);

        launch(12'hFFB, 4'd4);
        finish_op("opFFB", 4, 12'hFB0, 1'b0, 12'hFB0, 1'b0);
        tmp = otps1;
        chk12("opFFB_sra", tmp >>> 4, 12'hFFB);

        launch(12'h100, 4'd4);
        finish_op("op100", 4, 12'h7FF, 1'b1, 12'h000, 1'b1);

        launch(12'h800, 4'd1);
        finish_op("op800", 1, 12'h800, 1'b1, 12'h000, 1'b1);

        launch(12'h123, 4'd0);
        finish_op("op123", 0, 12'h123, 1'b0, 12'h123, 1'b0);

        // start re-pulsed mid-shift with another operand
        launch(12'h015, 4'd5);
        @(negedge clk);
        inpt  = 12'h7FF;
        sh    = 4'd1;
        start = 1'b1;
        chk12("repulse_hold", otps1, 12'h123);
        @(negedge clk);
        start = 1'b0;
        finish_op("repulse", 3, 12'h2A0, 1'b0, 12'h2A0, 1'b0);

        // start held high: second op accepted on the edge after DONE
        @(negedge clk);
        inpt  = 12'h003;
        sh    = 4'd2;
        start = 1'b1;
        @(negedge clk);
        inpt  = 12'h040;
        sh    = 4'd1;
        finish_op("held1", 2, 12'h00C, 1'b0, 12'h00C, 1'b0);
        @(negedge clk);
        start = 1'b0;
        finish_op("held2", 1, 12'h080, 1'b0, 12'h080, 1'b0);

        // asynchronous reset mid-shift
        launch(12'h001, 4'd8);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_busy", busy1, 1'b0);
        chk12("arst_otps", otps1, 12'h000);
        chk12("arst_otps_sat0", otps0, 12'h000);
        chk1("arst_ovf", ovf1, 1'b0);
        chk1("arst_done", done1, 1'b0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk1("arst_no_done", done1, 1'b0);
        end
        rst_n = 1'b1;
        launch(12'h00F, 4'd2);
        finish_op("post_rst", 2, 12'h03C, 1'b0, 12'h03C, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
